// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_pkg
// Description : Shared fetch-state encoding, reset PC and opcode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [6:0]  OP_I_ALU         = 7'h13;
  localparam logic [6:0]  OP_LUI           = 7'h37;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_register.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_pc_register
// Description : Program counter with redirect load, +4 advance and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit_pc_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_pc_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;

  // Wraps naturally modulo 2^DATA_WIDTH.
  assign pc_plus4_o = pc_q + DATA_WIDTH'(4);
  assign pc_o       = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_plus4_o;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Single-outstanding-request fetch stage feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] Instruction_bus_o,
  output logic [6:0]            op_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fetch_err_o
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                  err_q, err_d;

  logic                  pc_inc;
  logic                  pc_load;
  logic [DATA_WIDTH-1:0] pc_cur;
  logic [DATA_WIDTH-1:0] pc_cur_plus4;
  logic                  redir_ok;
  logic                  redir_bad;

  instruction_fetch_unit_pc_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_register (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_pc_i  (redirect_pc_i),
    .pc_o       (pc_cur),
    .pc_plus4_o (pc_cur_plus4)
  );

  assign redir_ok  = redirect_i &&  is_word_aligned(redirect_pc_i);
  assign redir_bad = redirect_i && !is_word_aligned(redirect_pc_i);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    err_d    = err_q | redir_bad;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pc_load = redir_ok;
        state_d = ST_FETCH;
        addr_d  = redir_ok ? redirect_pc_i : pc_cur;
      end
      ST_FETCH: begin
        if (redir_ok) begin
          pc_load = 1'b1;
          if (imem_ack_i) begin
            state_d = ST_FETCH;
            addr_d  = redirect_pc_i;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (imem_ack_i) begin
          instr_d  = imem_rdata_i;
          pc_out_d = addr_q;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redir_ok) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
          addr_d  = redirect_pc_i;
        end else if (instr_ready_i) begin
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
          addr_d  = pc_cur_plus4;
        end
      end
      ST_DRAIN: begin
        // A redirect coinciding with the draining ack still retires the old
        // request, so the new fetch starts from the freshest target.
        pc_load = redir_ok;
        if (imem_ack_i) begin
          state_d = ST_FETCH;
          addr_d  = redir_ok ? redirect_pc_i : pc_cur;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      err_q    <= err_d;
    end
  end

  // Request and valid decode straight from state so reset drops them at once.
  assign imem_req_o        = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign instr_valid_o     = (state_q == ST_HOLD);
  assign imem_addr_o       = addr_q;
  assign Instruction_bus_o = instr_q;
  assign op_o              = instr_q[6:0];
  assign pc_o              = pc_out_q;
  assign pc_plus4_o        = pc_out_q + DATA_WIDTH'(4);
  assign fetch_err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] Instruction_bus_o;
  logic [6:0]  op_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_err_o;

  logic        w_req, w_valid, w_err;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;
  logic [6:0]  w_op;
  logic        w_ack = 1'b0;
  logic        w_ready = 1'b0;
  logic [31:0] w_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ack_i        (imem_ack_i),
    .imem_rdata_i      (imem_rdata_i),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i),
    .Instruction_bus_o (Instruction_bus_o),
    .op_o              (op_o),
    .pc_o              (pc_o),
    .pc_plus4_o        (pc_plus4_o),
    .fetch_err_o       (fetch_err_o)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk               (clk),
    .reset             (reset),
    .redirect_i        (1'b0),
    .redirect_pc_i     (32'h0),
    .imem_req_o        (w_req),
    .imem_addr_o       (w_addr),
    .imem_ack_i        (w_ack),
    .imem_rdata_i      (w_rdata),
    .instr_valid_o     (w_valid),
    .instr_ready_i     (w_ready),
    .Instruction_bus_o (w_instr),
    .op_o              (w_op),
    .pc_o              (w_pc),
    .pc_plus4_o        (w_pc4),
    .fetch_err_o       (w_err)
  );

  // One clock, sampled 1ns after the edge; also checks req/valid exclusivity.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (imem_req_o && instr_valid_o) begin
      errors++;
      $display("FAIL req_valid_exclusive req=%b valid=%b required not both 1", imem_req_o, instr_valid_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_req_o, instr_valid_o, fetch_err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags req/valid/err=%b required 000", {imem_req_o, instr_valid_o, fetch_err_o});
    end
    checks++;
    if (imem_addr_o !== 32'h0040_0000 || pc_o !== 32'h0040_0000 || pc_plus4_o !== 32'h0040_0004) begin
      errors++;
      $display("FAIL reset_pc addr=%h pc=%h pc4=%h required 00400000/00400000/00400004", imem_addr_o, pc_o, pc_plus4_o);
    end
    checks++;
    if (Instruction_bus_o !== 32'h0000_0013 || op_o !== 7'h13) begin
      errors++;
      $display("FAIL reset_nop instr=%h op=%h required 00000013/13", Instruction_bus_o, op_o);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0000) begin
      errors++;
      $display("FAIL first_req req=%b addr=%h required 1/00400000", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_basic_fetch();
    tick();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0000 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_ack req=%b addr=%h valid=%b required 1/00400000/0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0050_0093;
    tick();
    imem_ack_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || Instruction_bus_o !== 32'h0050_0093
        || op_o !== 7'h13 || pc_o !== 32'h0040_0000 || pc_plus4_o !== 32'h0040_0004) begin
      errors++;
      $display("FAIL basic_present valid=%b req=%b instr=%h op=%h pc=%h pc4=%h required 1/0/00500093/13/00400000/00400004",
               instr_valid_o, imem_req_o, Instruction_bus_o, op_o, pc_o, pc_plus4_o);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0004) begin
      errors++;
      $display("FAIL next_req valid=%b req=%b addr=%h required 0/1/00400004", instr_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_hold_stable();
    imem_ack_i = 1'b1; imem_rdata_i = 32'h1234_5037;
    tick();
    imem_ack_i = 1'b0; imem_rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) imem_ack_i = 1'b1;
      tick();
      imem_ack_i = 1'b0;
      checks++;
      if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || Instruction_bus_o !== 32'h1234_5037
          || op_o !== 7'h37 || pc_o !== 32'h0040_0004 || pc_plus4_o !== 32'h0040_0008) begin
        errors++;
        $display("FAIL hold_stable[%0d] valid=%b req=%b instr=%h op=%h pc=%h pc4=%h required 1/0/12345037/37/00400004/00400008",
                 i, instr_valid_o, imem_req_o, Instruction_bus_o, op_o, pc_o, pc_plus4_o);
      end
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0008) begin
      errors++;
      $display("FAIL hold_next_req req=%b addr=%h required 1/00400008", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_wait();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0100;
    tick();
    redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0008 || instr_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold[%0d] req=%b addr=%h valid=%b required 1/00400008/0", i, imem_req_o, imem_addr_o, instr_valid_o);
      end
      if (i == 2) begin
        imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
      end
      tick();
    end
    imem_ack_i = 1'b0;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0100 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_done req=%b addr=%h valid=%b required 1/00400100/0", imem_req_o, imem_addr_o, instr_valid_o);
    end
  endtask

  task automatic test_redirect_ack();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0200;
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0037;
    tick();
    redirect_i = 1'b0; imem_ack_i = 1'b0;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0200 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redir_ack req=%b addr=%h valid=%b required 1/00400200/0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    imem_ack_i = 1'b1; imem_rdata_i = 32'h00A0_0113;
    tick();
    imem_ack_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0040_0200 || Instruction_bus_o !== 32'h00A0_0113) begin
      errors++;
      $display("FAIL redir_target_fetch valid=%b pc=%h instr=%h required 1/00400200/00a00113", instr_valid_o, pc_o, Instruction_bus_o);
    end
  endtask

  task automatic test_misaligned();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0102;
    tick();
    redirect_i = 1'b0;
    checks++;
    if (fetch_err_o !== 1'b1 || instr_valid_o !== 1'b1 || pc_o !== 32'h0040_0200) begin
      errors++;
      $display("FAIL misaligned err=%b valid=%b pc=%h required 1/1/00400200", fetch_err_o, instr_valid_o, pc_o);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    checks++;
    if (fetch_err_o !== 1'b1 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0204) begin
      errors++;
      $display("FAIL misaligned_continue err=%b req=%b addr=%h required 1/1/00400204", fetch_err_o, imem_req_o, imem_addr_o);
    end
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    tick();
    imem_ack_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0300;
    tick();
    redirect_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0300 || fetch_err_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_redirect valid=%b req=%b addr=%h err=%b required 0/1/00400300/1", instr_valid_o, imem_req_o, imem_addr_o, fetch_err_o);
    end
  endtask

  task automatic test_wrap();
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first_req req=%b addr=%h required 1/fffffffc", w_req, w_addr);
    end
    w_ack = 1'b1; w_rdata = 32'h0000_0013;
    tick();
    w_ack = 1'b0;
    checks++;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pc4 !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_present valid=%b pc=%h pc4=%h required 1/fffffffc/00000000", w_valid, w_pc, w_pc4);
    end
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_next_req req=%b addr=%h required 1/00000000", w_req, w_addr);
    end
  endtask

  task automatic test_async_reset();
    checks++;
    if (imem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req req=%b required 1", imem_req_o);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || imem_addr_o !== 32'h0040_0000 || fetch_err_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset req=%b valid=%b addr=%h err=%b required 0/0/00400000/0", imem_req_o, instr_valid_o, imem_addr_o, fetch_err_o);
    end
    imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD0_0037;
    tick();
    imem_ack_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0 || Instruction_bus_o !== 32'h0000_0013) begin
      errors++;
      $display("FAIL ack_in_reset valid=%b instr=%h required 0/00000013", instr_valid_o, Instruction_bus_o);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0040_0000 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_req req=%b addr=%h valid=%b required 1/00400000/0", imem_req_o, imem_addr_o, instr_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stable();
    test_redirect_wait();
    test_redirect_ack();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the immediate/decode logic.
- Owns the program counter and runs a one-outstanding-request handshake to instruction memory.
- Holds the fetched word in an instruction register and presents it, with its opcode field and PC, to decode under a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and squashes any in-flight fetch.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (program text base).
- DATA_WIDTH, 32, instruction and address width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_i  in  1  one-cycle pulse: load redirect_pc_i as the next fetch PC.
- redirect_pc_i  in  32  redirect target.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  32  fetch address; stable while imem_req_o is high.
- imem_ack_i  in  1  memory returns data this cycle; sampled only while imem_req_o=1.
- imem_rdata_i  in  32  instruction word, valid when imem_ack_i=1.
- instr_valid_o  out  1  Instruction_bus_o, op_o and pc_o are valid.
- instr_ready_i  in  1  decode consumes the instruction.
- Instruction_bus_o  out  32  registered instruction word.
- op_o  out  7  Instruction_bus_o[6:0].
- pc_o  out  32  PC of the presented instruction.
- pc_plus4_o  out  32  pc_o + 4, modulo 2^32.
- fetch_err_o  out  1  sticky flag: a misaligned redirect was received.

Behaviour:
- Reset (asynchronous assert, synchronous use after deassert):
  - pc = RESET_PC, state = IDLE.
  - imem_req_o = 0, imem_addr_o = RESET_PC, instr_valid_o = 0.
  - Instruction_bus_o = 32'h0000_0013 (NOP); op_o = 7'h13.
  - pc_o = RESET_PC; pc_plus4_o = RESET_PC+4; fetch_err_o = 0.
- FSM states: IDLE, FETCH, HOLD, DRAIN.
- IDLE: entered only from reset. Next cycle goes to FETCH with imem_addr_o = pc.
- FETCH:
  - imem_req_o = 1; imem_addr_o holds its value until ack.
  - An ack may arrive in the first cycle req is high.
  - On ack with no redirect: latch rdata into Instruction_bus_o and pc_o = imem_addr_o; go to HOLD.
- HOLD:
  - instr_valid_o = 1, imem_req_o = 0.
  - Outputs stay stable until instr_ready_i.
  - On ready: pc <= pc+4, go to FETCH; instr_valid_o drops the next cycle.
  - Throughput is at most one instruction per 2 cycles (accepted cost, no prefetch).
- Redirect (aligned target, redirect_pc_i[1:0]==0) has priority over ready and ack:
  - HOLD: instr_valid_o = 0 next cycle; pc <= target; go to FETCH.
  - FETCH with no ack: pc <= target; go to DRAIN.
  - FETCH with ack the same cycle: data is discarded; pc <= target; go to FETCH; new address appears next cycle.
  - DRAIN: pc <= target (last redirect wins); stay in DRAIN.
  - IDLE: pc <= target; go to FETCH.
- DRAIN:
  - imem_req_o = 1 with the old address held, per the memory protocol.
  - Ack data is discarded and never becomes valid; then go to FETCH at pc.
- Misaligned redirect:
  - fetch_err_o <= 1, held until reset.
  - Redirect is otherwise ignored: pc and state are unchanged.
- pc+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- imem_ack_i while imem_req_o=0 is ignored.
- Reset mid-transaction: all state clears immediately; any later ack is ignored because req=0.
- Invariant: instr_valid_o and imem_req_o are never both 1.

Decomposition:
- Shared package:
  - Fetch state encoding (2 bits).
  - RESET_PC default.
  - NOP_INSTR = 32'h0000_0013.
  - Opcode constants OP_I_ALU = 7'h13 and OP_LUI = 7'h37, also used by decode.
- One natural sub-module: pc_register. It holds the enabled PC with an async active-low reset to RESET_PC, a load-redirect path and a +4 adder.

Test Plan:
- Reset release, memory acks 1 cycle after req -> first req at 32'h0040_0000; instr_valid_o with pc_o=32'h0040_0000; after ready, next req at 32'h0040_0004.
- Ack in the same cycle as req, instr_ready_i held low for 5 cycles -> outputs stable throughout, no new req, op_o=rdata[6:0] (e.g. 7'h37 for 32'h12345037).
- Redirect to 32'h0040_0100 while FETCH is waiting, ack 3 cycles later -> req stays at the old address until ack, that data is never valid, next req is at 32'h0040_0100.
- Redirect and ack in the same cycle -> data dropped, next req address is the redirect target, instr_valid_o stays 0.
- Redirect to 32'h0040_0102 -> fetch_err_o=1 and stays set; sequential fetch continues unaffected.
- RESET_PC=32'hFFFF_FFFC, one instruction consumed -> next req at 32'h0000_0000; async reset asserted mid-FETCH -> req and valid drop without waiting for a clock edge.
